// File: rtl/upsample_window3x3.sv
// upsample_window3x3: turns a W x W raster plane into one zero-padded 3x3 window per pixel, in raster order.
// Latency: the window for centre p is presented one cycle after input p+W+1 is accepted; the last W+1 are flushed internally.
// Backpressure: single output register; input stalls while it is full and m_axis_tready is low.
// Optional feature macro: WINDOW_TLAST_CHECK_EN adds err_tlast, a sticky flag for a misplaced input tlast.
module upsample_window3x3 #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WIDTH  = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2:0]              cfg_size,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [9*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic                    done
`ifdef WINDOW_TLAST_CHECK_EN
  ,
  output logic                    err_tlast
`endif
);
  localparam int AW = $clog2(MAX_WIDTH);

  typedef enum logic [2:0] {IDLE, FILL, STREAM, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic [AW-1:0]           wm1;              // latched plane width minus one
  logic [AW-1:0]           in_col;           // column of the next pixel pushed (also line-buffer address)
  logic [AW:0]             in_row;           // row of the next pixel pushed; reaches W+1 during flush
  logic [AW-1:0]           cen_col;          // centre of the next window emitted
  logic [AW-1:0]           cen_row;
  logic [DATA_WIDTH-1:0]   lb_top [MAX_WIDTH];  // two rows above the incoming row
  logic [DATA_WIDTH-1:0]   lb_mid [MAX_WIDTH];  // one row above the incoming row
  logic [DATA_WIDTH-1:0]   win     [9];
  logic [DATA_WIDTH-1:0]   win_nxt [9];
  logic [9*DATA_WIDTH-1:0] win_pad;
  logic [DATA_WIDTH-1:0]   pix;
  logic out_free, accept, push, advance, emit;
  logic last_in, fill_end, cen_last, out_last_pend;

  function automatic logic [AW-1:0] size_to_wm1(input logic [2:0] sz);
    logic [7:0] w;
    case (sz)
      3'd1:    w = 8'd16;
      3'd2:    w = 8'd32;
      3'd3:    w = 8'd64;
      3'd4:    w = 8'd128;
      default: w = 8'd8;
    endcase
    return AW'(w - 8'd1);
  endfunction

  // Handshake qualifiers; flush pushes zeros and stops once the tlast window is loaded.
  always_comb begin
    out_free      = !m_axis_tvalid || m_axis_tready;
    s_axis_tready = ((state == FILL) || (state == STREAM)) && out_free;
    accept        = s_axis_tvalid && s_axis_tready;
    out_last_pend = m_axis_tvalid && m_axis_tlast;
    push          = (state == FLUSH) && out_free && !out_last_pend;
    advance       = accept || push;
    emit          = advance && (state != FILL);
    pix           = (state == FLUSH) ? '0 : s_axis_tdata;
    last_in       = (in_row == {1'b0, wm1}) && (in_col == wm1);
    fill_end      = (in_row == (AW+1)'(1)) && (in_col == '0);
    cen_last      = (cen_row == wm1) && (cen_col == wm1);
  end

  // Shift the window left by one column; the new right column comes from the line buffers and the pushed pixel.
  always_comb begin
    for (int dy = 0; dy < 3; dy++) begin
      win_nxt[3*dy]   = win[3*dy+1];
      win_nxt[3*dy+1] = win[3*dy+2];
    end
    win_nxt[2] = lb_top[in_col];
    win_nxt[5] = lb_mid[in_col];
    win_nxt[8] = pix;
  end

  // Zero taps that fall outside the plane; this also hides stale line-buffer and wrap-around data.
  always_comb begin
    win_pad = '0;
    for (int k = 0; k < 9; k++) begin
      if (!(((k < 3) && (cen_row == '0)) || ((k >= 6) && (cen_row == wm1)) ||
            ((k % 3 == 0) && (cen_col == '0)) || ((k % 3 == 2) && (cen_col == wm1))))
        win_pad[k*DATA_WIDTH +: DATA_WIDTH] = win_nxt[k];
    end
  end

  // Next-state logic plus busy/done decoded from the state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = FILL;
      FILL:   begin busy = 1'b1; if (accept && fill_end) state_nxt = STREAM; end
      STREAM: begin busy = 1'b1; if (accept && last_in) state_nxt = FLUSH; end
      FLUSH:  begin busy = 1'b1; if (out_last_pend && m_axis_tready) state_nxt = DONE; end
      DONE:   begin done = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Width latch and position counters; a start in IDLE begins a clean frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wm1 <= '0; in_col <= '0; in_row <= '0; cen_col <= '0; cen_row <= '0;
    end else if ((state == IDLE) && start) begin
      wm1 <= size_to_wm1(cfg_size);
      in_col <= '0; in_row <= '0; cen_col <= '0; cen_row <= '0;
    end else begin
      if (advance) begin
        if (in_col == wm1) begin in_col <= '0; in_row <= in_row + 1'b1; end
        else in_col <= in_col + 1'b1;
      end
      if (emit) begin
        if (cen_col == wm1) begin cen_col <= '0; cen_row <= cen_row + 1'b1; end
        else cen_col <= cen_col + 1'b1;
      end
    end
  end

  // Window register advances with every pushed pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 9; k++) win[k] <= '0;
    end else if (advance) begin
      for (int k = 0; k < 9; k++) win[k] <= win_nxt[k];
    end
  end

  // Output register: load on emit, drop valid on handshake, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_axis_tvalid <= 1'b0; m_axis_tdata <= '0; m_axis_tlast <= 1'b0;
    end else if (emit) begin
      m_axis_tvalid <= 1'b1; m_axis_tdata <= win_pad; m_axis_tlast <= cen_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0; m_axis_tlast <= 1'b0;
    end
  end

  // Line buffers: read-before-write at the column address, rows cascade mid -> top.
  always_ff @(posedge clk) begin
    if (advance) begin
      lb_mid[in_col] <= pix;
      lb_top[in_col] <= lb_mid[in_col];
    end
  end

`ifdef WINDOW_TLAST_CHECK_EN
  // Sticky flag: accepted tlast must be high exactly on the final pixel of the plane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      err_tlast <= 1'b0;
    else if ((state == IDLE) && start) err_tlast <= 1'b0;
    else if (accept && (s_axis_tlast != last_in)) err_tlast <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif

endmodule

// File: tb/tb_upsample_window3x3.sv
module tb_upsample_window3x3;
  localparam int DW = 16;
  localparam int WB = 9*DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    cfg_size;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, s_tready;
  logic [WB-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tready;
  logic          busy, done;
`ifdef WINDOW_TLAST_CHECK_EN
  logic          err_tlast;
  logic          err_at_start;
`endif

  upsample_window3x3 #(.DATA_WIDTH(DW), .MAX_WIDTH(128)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_size(cfg_size),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .busy(busy), .done(done)
`ifdef WINDOW_TLAST_CHECK_EN
    , .err_tlast(err_tlast)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [WB-1:0] got_dat [16384];
  logic          got_last [16384];
  int nwin, acc, first_at, stall_err, cyc;
  bit fin;

  task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WB-1:0] pack9(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
    logic [WB-1:0] v;
    v = {DW'(t8), DW'(t7), DW'(t6), DW'(t5), DW'(t4), DW'(t3), DW'(t2), DW'(t1), DW'(t0)};
    return v;
  endfunction

  // Reference window: zero-padded neighbourhood of pixel value (r*w+c+off).
  function automatic logic [WB-1:0] model(input int w, input int idx, input int off);
    logic [WB-1:0] v;
    int cr, cc, r, c;
    v = '0;
    cr = idx / w;
    cc = idx % w;
    for (int k = 0; k < 9; k++) begin
      r = cr + k/3 - 1;
      c = cc + k%3 - 1;
      if (r >= 0 && r < w && c >= 0 && c < w) v[k*DW +: DW] = DW'(r*w + c + off);
    end
    return v;
  endfunction

  task automatic drive_in(input int w, input int off, input int stop_after, input int bad_idx);
    s_tvalid = (acc < w*w) && (stop_after == 0 || acc < stop_after);
    s_tdata  = DW'(acc + off);
    s_tlast  = (acc == w*w-1) || (acc == bad_idx);
  endtask

  // Runs one frame from a start pulse; called at posedge+1. mode 1 = ready pattern 1,0,0,1.
  task automatic run_frame(input int w, input logic [2:0] cfg, input int off, input int mode,
                           input int stop_after, input int restart_at, input int bad_idx);
    int budget;
    bit acc_now, hs, prev_stall, prev_last;
    logic [WB-1:0] prev_dat;
    nwin = 0; acc = 0; first_at = -1; stall_err = 0; fin = 0; cyc = 0;
    prev_stall = 0; prev_last = 0; prev_dat = '0;
    for (int i = 0; i < w*w; i++) begin got_dat[i] = 'x; got_last[i] = 1'bx; end
    budget = 4*w*w + 4*w + 100;
    start = 1'b1; cfg_size = cfg; m_tready = 1'b1;
    drive_in(w, off, stop_after, bad_idx);
    while (!fin && cyc < budget && !(stop_after > 0 && acc >= stop_after)) begin
      @(negedge clk);
      if (m_tvalid && !m_tready && s_tready) stall_err++;
      if (prev_stall && (!m_tvalid || m_tdata !== prev_dat || m_tlast !== prev_last)) stall_err++;
      if (m_tvalid && first_at < 0) first_at = acc;
      acc_now = s_tvalid && s_tready;
      hs = m_tvalid && m_tready;
      if (hs) begin
        if (nwin < 16384) begin got_dat[nwin] = m_tdata; got_last[nwin] = m_tlast; end
        nwin++;
        if (m_tlast) fin = 1;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_dat = m_tdata;
      prev_last = m_tlast;
      @(posedge clk); #1;
      if (acc_now) acc++;
      cyc++;
      start = 1'b0;
      if (cyc == restart_at) begin start = 1'b1; cfg_size = 3'd4; end
      m_tready = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      drive_in(w, off, stop_after, bad_idx);
`ifdef WINDOW_TLAST_CHECK_EN
      if (cyc == 1) err_at_start = err_tlast;
`endif
    end
    start = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
  endtask

  task automatic check_seq(input string tag, input int w, input int off);
    int bad, lbad;
    bad = 0; lbad = 0;
    check({tag, "_done_seen"}, fin, 1);
    check({tag, "_nwin"}, nwin, w*w);
    for (int i = 0; i < w*w; i++) begin
      if (got_dat[i] !== model(w, i, off)) bad++;
      if (got_last[i] !== (i == w*w-1)) lbad++;
    end
    check({tag, "_bad_windows"}, bad, 0);
    check({tag, "_bad_tlast"}, lbad, 0);
  endtask

  task automatic check_end(input string tag);
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_busy_low"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_done_cleared"}, done, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; cfg_size = 3'd0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    #3;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk); reset = 1'b1;
    s_tvalid = 1'b1;
    @(posedge clk); #1;
    check("idle_tready_low", s_tready, 0);
    s_tvalid = 1'b0;

    // W=8, both sides always ready
    run_frame(8, 3'd0, 1, 0, 0, -1, -1);
    check("a_frame_cycles", cyc, 75);
    check("a_first_valid_accepts", first_at, 10);
    check("a_win0", got_dat[0], pack9(0,0,0,0,1,2,0,9,10));
    check("a_win_r3c4", got_dat[28], pack9(20,21,22,28,29,30,36,37,38));
    check("a_win_last", got_dat[63], pack9(55,56,0,63,64,0,0,0,0));
    check("a_last_tlast", got_last[63], 1);
    check_end("a");
    check_seq("a", 8, 1);

    // W=8 with output ready pattern 1,0,0,1
    run_frame(8, 3'd0, 1, 1, 0, -1, -1);
    check("b_stall_errors", stall_err, 0);
    check_end("b");
    check_seq("b", 8, 1);

    // W=128, pixel = index
    run_frame(128, 3'd4, 0, 0, 0, -1, -1);
    check("c_first_valid_accepts", first_at, 130);
    check("c_win_r127c0", got_dat[16256], pack9(0,16128,16129,0,16256,16257,0,0,0));
    check_end("c");
    check_seq("c", 128, 0);

    // Reset after 30 inputs of a W=8 frame
    run_frame(8, 3'd0, 1, 0, 30, -1, -1);
    check("d_accepts_before_reset", acc, 30);
    check("d_valid_before_reset", m_tvalid, 1);
    reset = 1'b0;
    #1;
    check("d_rst_tvalid", m_tvalid, 0);
    check("d_rst_tdata", m_tdata, 0);
    check("d_rst_tlast", m_tlast, 0);
    check("d_rst_tready", s_tready, 0);
    check("d_rst_busy", busy, 0);
    check("d_rst_done", done, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    run_frame(8, 3'd0, 1, 0, 0, -1, -1);
    check_end("d");
    check_seq("d", 8, 1);

    // Start pulse mid-frame (with cfg_size=4) must be ignored
    run_frame(8, 3'd0, 1, 0, 0, 20, -1);
    check_end("e");
    check_seq("e", 8, 1);

    // cfg_size=6 falls back to W=8
    run_frame(8, 3'd6, 1, 0, 0, -1, -1);
    check_end("f");
    check_seq("f", 8, 1);

`ifdef WINDOW_TLAST_CHECK_EN
    run_frame(8, 3'd0, 1, 0, 0, -1, 10);
    check("g_err_after_bad_frame", err_tlast, 1);
    check_end("g");
    check_seq("g", 8, 1);
    run_frame(8, 3'd0, 1, 0, 0, -1, -1);
    check("h_err_cleared_by_start", err_at_start, 0);
    check("h_err_clean_frame", err_tlast, 0);
    check_end("h");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/upsample_window3x3.md
Name: upsample_window3x3

Overview:
- Downstream neighbour of the upsample AXI wrapper: consumes its raster output stream (one W×W channel plane per frame) and emits one zero-padded 3×3 neighbourhood per pixel, in raster order, to the following 3×3 convolution stage.
- Line-buffered: two row memories plus a 3×3 register window.
- One frame per start pulse.

Parameters:
- DATA_WIDTH, 16: pixel width in bits.
- MAX_WIDTH, 128: largest supported plane width; sizes each line buffer.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- cfg_size  in  3  sampled at start; 0..4 gives W=8,16,32,64,128; values 5..7 are treated as 0.
- s_axis_tdata  in  DATA_WIDTH  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  end-of-plane marker; used only by the optional check.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  9*DATA_WIDTH  packed window.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  asserted on the last window of the plane.
- m_axis_tready  in  1  output ready.
- busy  out  1  high from the start pulse until done.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (asynchronous, active low): state=IDLE; all outputs 0; counters 0. Line-buffer contents are not cleared (they are masked by padding logic).
- Window definition for centre (r,c), with r,c in 0..W-1:
  - tap k=3*dy+dx, where dy,dx in 0..2.
  - tap k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
  - value = pixel(r+dy-1, c+dx-1), or 0 if that coordinate lies outside 0..W-1.
- Exactly W*W windows per frame, emitted in raster order of centre.
- States:
  - IDLE: s_axis_tready=0. On start: latch W, set busy=1, go to FILL.
  - FILL: accept input; no output until W+2 pixels have been accepted (index W+1), then go to STREAM.
  - STREAM: every input accept produces one window. m_axis_tvalid rises the cycle after the accepting edge. After input pixel W*W-1 is accepted, go to FLUSH.
  - FLUSH: s_axis_tready=0. The block internally pushes W+1 zero pixels, each producing one window under the same handshake.
  - DONE: entered after the handshake of the window with m_axis_tlast=1. Pulses done=1 for one cycle, clears busy, returns to IDLE.
- Handshake:
  - Output register holds m_axis_tdata, m_axis_tvalid and m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
  - s_axis_tready = (state is FILL or STREAM) and (output register empty or m_axis_tready).
  - With both sides always ready, throughput is 1 window/cycle.
  - No window is dropped or duplicated under any ready pattern.
- m_axis_tlast is asserted only on the window for centre (W-1,W-1).
- Counters: column counter 0..W-1 wraps to 0 and increments the row counter. The line-buffer address equals the column counter. Counter and address widths are sized for MAX_WIDTH.
- start while busy: ignored. cfg_size changes mid-frame: ignored.
- s_axis_tvalid outside FILL/STREAM: ignored, with s_axis_tready=0.
- Reset mid-frame: immediate return to IDLE with outputs 0. The next start begins a clean frame with no stale windows.

Optional Feature:
- Macro: WINDOW_TLAST_CHECK_EN.
- When defined:
  - Adds output port err_tlast (1 bit, reset 0).
  - err_tlast sets, and stays set, if an accepted input has s_axis_tlast inconsistent with its index (1 at any index other than W*W-1, or 0 at index W*W-1).
  - err_tlast clears only on reset or start.
  - Streaming behaviour is unchanged.
- When undefined: the port is absent and s_axis_tlast is ignored.

Test Plan:
- W=8 (cfg_size=0), pixel(r,c)=8r+c+1, both sides always ready:
  - 64 windows.
  - Window 0 taps = {0,0,0,0,1,2,0,9,10}.
  - Centre (3,4) taps = {20,21,22,28,29,30,36,37,38}.
  - Last window taps = {55,56,0,63,64,0,0,0,0} with m_axis_tlast=1.
  - done pulses the cycle after the last handshake; busy=0 afterwards.
- Same frame with m_axis_tready pattern 1,0,0,1 repeating:
  - Identical 64-window sequence.
  - tdata held stable during stalls.
  - s_axis_tready=0 whenever output is full and not ready.
- W=128 (cfg_size=4), pixel = index mod 65536:
  - 16384 windows.
  - Centre (127,0) taps = {0,16128,16129,0,16256,16257,0,0,0}.
  - First m_axis_tvalid appears after 130 input accepts.
- reset=0 asserted after 30 inputs of a W=8 frame:
  - All outputs 0 immediately.
  - A new frame started afterwards reproduces the first scenario's windows exactly.
- Second start pulse mid-frame, plus cfg_size=6 at a later start:
  - The mid-frame start has no effect.
  - The later frame uses W=8.
- WINDOW_TLAST_CHECK_EN defined:
  - s_axis_tlast=1 at index 10 sets err_tlast; it stays 1 through frame end and is cleared by the next start.
  - A correct-tlast frame keeps err_tlast=0.
